div16_seq: RTL

//  Sequential restoring divider (shift-subtract), the inverse of the shift-add multiplier block.

---
 rtl/div_pkg.sv | 12 +
 rtl/div_step.sv | 23 ++
 rtl/div16_seq.sv | 128 ++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: default width and FSM state encoding.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder and trial-subtract the divisor, keeping the difference when it does not borrow.
module div_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic             q_msb_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] r_o,
  output logic             q_bit_o
);

  logic [WIDTH:0]   r_sh;
  logic [WIDTH-1:0] diff;

  // The remainder is always below the divisor, so a non-borrowing difference fits in
  // WIDTH bits and the modular low-order subtract is exact.
  assign r_sh    = {r_i, q_msb_i};
  assign diff    = r_sh[WIDTH-1:0] - b_i;
  assign q_bit_o = (r_sh >= {1'b0, b_i});
  assign r_o     = q_bit_o ? diff : r_sh[WIDTH-1:0];

endmodule

// File: rtl/div16_seq.sv
// Sequential restoring divider, one quotient bit per clock, with start/busy/done handshake.
// state   | meaning
// IDLE    | waiting for start; start is ignored during the done cycle
// RUN     | one iteration per edge; a zero divisor takes a single empty pass here
// DONE    | publish quot/rem, pulse done, drop busy
module div16_seq
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             busy,
  output logic             done,
  output logic             div0
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div0_q, div0_d;

  logic [WIDTH-1:0] step_r;
  logic             step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_i     (r_q),
    .q_msb_i (q_q[WIDTH-1]),
    .b_i     (b_q),
    .r_o     (step_r),
    .q_bit_o (step_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      b_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      b_q     <= b_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      div0_q  <= div0_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    b_d     = b_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    div0_d  = div0_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !done_q) begin
          b_d     = bin;
          q_d     = ain;
          r_d     = '0;
          busy_d  = 1'b1;
          div0_d  = (bin == '0);
          // Zero divisor runs one empty RUN pass so done lands two clocks after accept.
          cnt_d   = (bin == '0) ? CW'(1) : CW'(WIDTH);
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!div0_q) begin
          r_d = step_r;
          q_d = {q_q[WIDTH-2:0], step_q};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
        if (div0_q) begin
          quot_d = '1;
          rem_d  = q_q;
        end else begin
          quot_d = q_q;
          rem_d  = r_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign quot = quot_q;
  assign rem  = rem_q;
  assign busy = busy_q;
  assign done = done_q;
  assign div0 = div0_q;

endmodule
